ball_renderer: RTL and testbench



---
 rtl/ball_renderer_if.sv | 28 ++
 rtl/ball_renderer.sv | 116 +++++++++++
 tb/tb_ball_renderer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_renderer_if.sv
// Motion-step handshake between the ball renderer (requester) and the ball motion block.
// The renderer owns step_req and the shadow position; the motion block returns a new position.
interface ball_renderer_if;
    logic        step_req;
    logic [11:0] cur_x;
    logic [11:0] cur_y;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        pos_valid;

    modport master (
        output step_req,
        output cur_x,
        output cur_y,
        input  pos_x,
        input  pos_y,
        input  pos_valid
    );

    modport slave (
        input  step_req,
        input  cur_x,
        input  cur_y,
        output pos_x,
        output pos_y,
        output pos_valid
    );
endinterface

// File: rtl/ball_renderer.sv
// Per-frame shadow of the ball position, refreshed once at vertical-blank start, plus a
// registered pixel-level ball mask for the colour mux.
module ball_renderer #(
    parameter int unsigned BallSize = 20,
    parameter int unsigned ResetX   = 310,
    parameter int unsigned ResetY   = 230,
    parameter int unsigned Timeout  = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            vblank_start_i,
    input  logic            pix_active_i,
    input  logic [11:0]     pix_x_i,
    input  logic [11:0]     pix_y_i,
    ball_renderer_if.master motion_io,
    output logic            ball_on_o,
    output logic            stale_o,
    output logic [15:0]     frame_cnt_o
);

    localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              step_req_q, step_req_d;
    logic [11:0]       cur_x_q, cur_x_d;
    logic [11:0]       cur_y_q, cur_y_d;
    logic              stale_q, stale_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              ball_on_q;
    logic              hit;
    logic [12:0]       x_lo, x_hi, y_lo, y_hi;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_req_d  = 1'b0;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        stale_d     = stale_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (vblank_start_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                step_req_d = 1'b1;
                cnt_d      = '0;
                state_d    = StWait;
            end
            StWait: begin
                // A response on the final timeout cycle still counts.
                if (motion_io.pos_valid) begin
                    cur_x_d     = motion_io.pos_x;
                    cur_y_d     = motion_io.pos_y;
                    stale_d     = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end else if (cnt_q == CntW'(Timeout - 1)) begin
                    stale_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bounds are widened to 13 bits so a ball near column/row 4095 does not wrap to 0.
    always_comb begin
        x_lo = {1'b0, cur_x_q};
        y_lo = {1'b0, cur_y_q};
        x_hi = x_lo + 13'(BallSize - 1);
        y_hi = y_lo + 13'(BallSize - 1);
        hit  = pix_active_i
            && ({1'b0, pix_x_i} >= x_lo) && ({1'b0, pix_x_i} <= x_hi)
            && ({1'b0, pix_y_i} >= y_lo) && ({1'b0, pix_y_i} <= y_hi);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            step_req_q  <= 1'b0;
            cur_x_q     <= 12'(ResetX);
            cur_y_q     <= 12'(ResetY);
            stale_q     <= 1'b0;
            frame_cnt_q <= '0;
            ball_on_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_req_q  <= step_req_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            stale_q     <= stale_d;
            frame_cnt_q <= frame_cnt_d;
            ball_on_q   <= hit;
        end
    end

    assign motion_io.step_req = step_req_q;
    assign motion_io.cur_x    = cur_x_q;
    assign motion_io.cur_y    = cur_y_q;
    assign ball_on_o          = ball_on_q;
    assign stale_o            = stale_q;
    assign frame_cnt_o        = frame_cnt_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Scoreboard bench for ball_renderer: stimulus pushes expectations from a frame/pixel-level
// model into queues, and a negedge monitor pops and compares against the DUT outputs.
module tb_ball_renderer;

    localparam int BallSize = 20;
    localparam int ResetX   = 310;
    localparam int ResetY   = 230;
    localparam int Timeout  = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblank = 1'b0;
    logic        pact = 1'b0;
    logic [11:0] px = '0;
    logic [11:0] py = '0;
    logic        ball_on;
    logic        stale;
    logic [15:0] frame_cnt;

    ball_renderer_if mif ();

    ball_renderer #(
        .BallSize (BallSize),
        .ResetX   (ResetX),
        .ResetY   (ResetY),
        .Timeout  (Timeout)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .vblank_start_i (vblank),
        .pix_active_i   (pact),
        .pix_x_i        (px),
        .pix_y_i        (py),
        .motion_io      (mif),
        .ball_on_o      (ball_on),
        .stale_o        (stale),
        .frame_cnt_o    (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: what the shadow should hold, at frame granularity.
    int mx = ResetX;
    int my = ResetY;
    bit mstale = 1'b0;
    int mcnt = 0;

    typedef struct { int due; bit val; } ball_t;
    typedef struct { int x; int y; bit st; int cnt; string tag; } snap_t;

    ball_t q_ball[$];
    int    q_step[$];
    snap_t q_snap[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic bit model_hit(input bit a, input int x, input int y);
        return a && x >= mx && x <= mx + BallSize - 1 && y >= my && y <= my + BallSize - 1;
    endfunction

    task automatic push_snap(input string tag);
        snap_t s;
        s.x = mx; s.y = my; s.st = mstale; s.cnt = mcnt; s.tag = tag;
        q_snap.push_back(s);
    endtask

    // Monitor
    always @(negedge clk) begin
        ball_t b;
        snap_t s;
        int    d;
        if (rst_n) begin
            while (q_ball.size() > 0 && q_ball[0].due <= cyc) begin
                b = q_ball.pop_front();
                check("ball_on", ball_on, b.val);
            end
            if (mif.step_req) begin
                if (q_step.size() == 0) begin
                    check("step_req_unexpected", mif.step_req, 0);
                end else begin
                    d = q_step.pop_front();
                    check("step_req_cycle", cyc, d);
                end
            end
            while (q_snap.size() > 0) begin
                s = q_snap.pop_front();
                check({s.tag, ".cur_x"}, mif.cur_x, s.x);
                check({s.tag, ".cur_y"}, mif.cur_y, s.y);
                check({s.tag, ".stale"}, stale, s.st);
                check({s.tag, ".frame_cnt"}, frame_cnt, s.cnt);
            end
        end
    end

    task automatic pix(input bit a, input int x, input int y);
        ball_t b;
        @(posedge clk); #1;
        pact = a; px = 12'(x); py = 12'(y);
        b.due = cyc + 1;
        b.val = model_hit(a, int'(px), int'(py));
        q_ball.push_back(b);
    endtask

    task automatic pix_off();
        @(posedge clk); #1;
        pact = 1'b0;
    endtask

    // One frame: vblank pulse, then optionally answer d+1 cycles after the step_req cycle.
    task automatic frame(input bit respond, input int d, input int nx, input int ny,
                         input bit extra_vb);
        bit seen = 1'b0;
        int sr_cyc = 0;
        @(posedge clk); #1;
        vblank = 1'b1;
        q_step.push_back(cyc + 2);
        @(posedge clk); #1;
        vblank = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (mif.step_req) begin
                seen = 1'b1;
                sr_cyc = cyc;
            end
        end
        if (!seen) begin
            check("step_req_seen", mif.step_req, 1);
            void'(q_step.pop_front());
            return;
        end
        for (int k = 0; k <= d; k++) begin
            @(posedge clk); #1;
            vblank = extra_vb && (k == 0);
        end
        if (respond) begin
            mif.pos_valid = 1'b1;
            mif.pos_x = 12'(nx);
            mif.pos_y = 12'(ny);
            @(posedge clk); #1;
            mif.pos_valid = 1'b0;
            vblank = 1'b0;
        end
        vblank = 1'b0;
        if (respond && (d + 1 < Timeout)) begin
            mx = nx & 12'hFFF; my = ny & 12'hFFF; mstale = 1'b0; mcnt = (mcnt + 1) % 65536;
            push_snap("update");
        end else begin
            while (cyc < sr_cyc + Timeout + 2) begin
                @(posedge clk); #1;
            end
            mstale = 1'b1;
            push_snap("timeout");
        end
    endtask

    task automatic idle_pos(input int nx, input int ny);
        @(posedge clk); #1;
        mif.pos_valid = 1'b1; mif.pos_x = 12'(nx); mif.pos_y = 12'(ny);
        @(posedge clk); #1;
        mif.pos_valid = 1'b0;
        push_snap("idle_pos");
    endtask

    task automatic rand_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pix($urandom_range(0, 3) != 0, mx + int'($urandom_range(0, 29)) - 5,
                my + int'($urandom_range(0, 29)) - 5);
        end
        pix_off();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        mif.pos_valid = 1'b0;
        mif.pos_x = '0;
        mif.pos_y = '0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("reset.cur_x", mif.cur_x, ResetX);
        check("reset.cur_y", mif.cur_y, ResetY);
        check("reset.ball_on", ball_on, 0);
        check("reset.step_req", mif.step_req, 0);
        check("reset.stale", stale, 0);
        check("reset.frame_cnt", frame_cnt, 0);

        frame(1'b1, 0, 100, 50, 1'b0);
        pix(1, 100, 50);
        pix(1, 119, 69);
        pix(1, 120, 69);
        pix(1, 100, 49);
        pix(0, 105, 55);
        pix(1, 99, 60);
        pix(1, 110, 70);
        pix_off();

        frame(1'b0, 0, 0, 0, 1'b0);
        frame(1'b1, 5, 200, 200, 1'b0);
        idle_pos(7, 7);
        frame(1'b1, 10, 300, 100, 1'b1);
        frame(1'b1, Timeout - 2, 400, 123, 1'b0);
        frame(1'b1, Timeout - 1, 17, 17, 1'b0);

        frame(1'b1, 3, 4090, 4085, 1'b0);
        pix(1, 5, 4090);
        pix(1, 4095, 4090);
        pix(1, 4090, 5);
        pix(1, 4, 4086);
        pix(1, 4090, 4085);
        pix_off();

        for (int f = 0; f < 10; f++) begin
            frame($urandom_range(0, 6) != 0, int'($urandom_range(0, 70)),
                  int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                  $urandom_range(0, 1) == 1);
            rand_pixels(15);
        end

        frame(1'b0, 0, 0, 0, 1'b0);
        @(posedge clk); #1;
        vblank = 1'b1;
        q_step.push_back(cyc + 2);
        @(posedge clk); #1;
        vblank = 1'b0;
        pact = 1'b1; px = 12'(mx + 1); py = 12'(my + 1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        mx = ResetX; my = ResetY; mstale = 1'b0; mcnt = 0;
        check("async_reset.cur_x", mif.cur_x, mx);
        check("async_reset.cur_y", mif.cur_y, my);
        check("async_reset.ball_on", ball_on, 0);
        check("async_reset.step_req", mif.step_req, 0);
        check("async_reset.stale", stale, mstale);
        check("async_reset.frame_cnt", frame_cnt, mcnt);
        pact = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        idle_pos(55, 66);
        repeat (10) @(posedge clk);
        frame(1'b1, 2, 250, 260, 1'b0);
        pix(1, 250, 260);
        pix(1, 269, 279);
        pix(1, 270, 279);
        pix_off();

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queues_drained", q_ball.size() + q_step.size() + q_snap.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
